y86_fetch_datapath: RTL and testbench
=====================================

// Module: y86_fetch_datapath
// PURPOSE
// Y86-64 fetch/execute datapath slice: byte-addressed instruction memory with a
// 10-byte combinational read window, the fetch-field aligner (rA/rB/valC
// extraction) and the 64-bit execute ALU with condition-flag generation.
// Sits between the PC-select logic and the F->D / E->M pipeline registers.
// Only the memory array is clocked; all other paths are purely combinational.
// PARAMETERS
// MEM_BYTES  1024  instruction memory size in bytes (addresses 0..MEM_BYTES-1)
// PORTS
// clock        in   1   single clock; array writes on rising edge
// resetting    in   1   asynchronous, active-low reset (0 = reset; tied 1 in normal run)
// load_en      in   1   program-load write enable
// load_addr    in   64  program-load byte address
// load_data    in   8   program-load byte
// f_pc         in   64  fetch address
// need_regids  in   1   1 = instruction carries a register-specifier byte
// aluA         in   64  ALU operand A
// aluB         in   64  ALU operand B
// alufun       in   4   ALU function: 0 add, 1 sub, 2 and, 3 xor
// f_ibyte      out  8   mem[f_pc] (icode:ifun byte)
// f_ibytes     out  72  bytes mem[f_pc+1..f_pc+9]; f_ibytes[8k+7:8k] = mem[f_pc+1+k]
// imem_error   out  1   fetch address invalid
// f_rA, f_rB   out  4   register specifiers
// f_valC       out  64  constant word, little-endian
// e_valE       out  64  ALU result
// new_cc       out  3   {ZF,SF,OF} computed from current ALU operation
// BEHAVIOUR
// - Reset (resetting=0, async): every memory byte cleared to 8'h00 (halt); held
//   while low; loads ignored. Outputs follow combinationally from cleared array.
// - Load: on posedge clock with load_en=1 and load_addr<MEM_BYTES, mem[load_addr]
//   <= load_data; out-of-range load addresses silently dropped.
// - Read: combinational, zero latency; a byte written at edge N is visible on
//   f_ibyte/f_ibytes after that edge (old value before it, no bypass).
// - imem_error = 1 iff f_pc >= MEM_BYTES. Any window byte whose address
//   >= MEM_BYTES (incl. wrap of f_pc+k) reads as 8'h00; f_ibyte=00 when error.
// - Align: need_regids=1 -> f_rA=f_ibytes[7:4], f_rB=f_ibytes[3:0],
//   f_valC=f_ibytes[71:8]; need_regids=0 -> f_rA=f_rB=4'hF (RNONE),
//   f_valC=f_ibytes[63:0].
// - ALU (all mod 2^64): add e_valE=aluB+aluA; sub e_valE=aluB-aluA;
//   and aluB&aluA; xor aluB^aluA; alufun>=4 -> e_valE=0.
// - Flags: ZF=(e_valE==0); SF=e_valE[63];
//   OF add = (aluA[63]==aluB[63]) & (e_valE[63]!=aluA[63]);
//   OF sub = (aluA[63]!=aluB[63]) & (e_valE[63]!=aluB[63]); OF=0 for and/xor/invalid.
// - new_cc is not registered here; downstream CC register decides whether to latch.
// STRUCTURE
// - Shared package: ALU function codes (ALUADD..ALUXOR), RNONE=4'hF, icode
//   constants, status codes (SAOK/SHLT/SADR/SINS) used across the pipeline.
// - One sub-module: y86_alu64 (aluA, aluB, alufun -> e_valE, new_cc); memory
//   array and aligner coded inline.
// TESTING
// - Reset low then high, f_pc=0 -> f_ibyte=00, f_ibytes=0, imem_error=0, f_rA=f_rB=F.
// - Load 30 F2 08 00 00 00 00 00 00 00 at 0..9, need_regids=1, f_pc=0 ->
//   f_ibyte=30, f_rA=F, f_rB=2, f_valC=64'h8.
// - Load 70 10 00 00 00 00 00 00 00 at 0x20, need_regids=0, f_pc=0x20 ->
//   f_rA=f_rB=F, f_valC=64'h10; f_pc=1024 -> imem_error=1, f_ibyte=00.
// - add A=7FFF_FFFF_FFFF_FFFF, B=1 -> e_valE=8000_0000_0000_0000, cc=011;
//   sub A=5,B=5 -> 0, cc=100.
// - and A=F0,B=0F -> 0, cc=100; xor A=-1,B=0 -> all ones, cc=010; alufun=7 -> 0, cc=100.
// - Assert reset mid-load (load_en=1) -> write ignored, array reads 00 afterwards.

Source files
------------

// File: rtl/y86_fetch_datapath_pkg.sv
// Shared Y86-64 pipeline constants: ALU function codes, register and
// instruction encodings, and processor status codes.
package y86_fetch_datapath_pkg;

   localparam logic [3:0] ALUADD = 4'h0;
   localparam logic [3:0] ALUSUB = 4'h1;
   localparam logic [3:0] ALUAND = 4'h2;
   localparam logic [3:0] ALUXOR = 4'h3;

   localparam logic [3:0] RNONE  = 4'hF;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   typedef enum logic [2:0] {
      SAOK = 3'd1,
      SHLT = 3'd2,
      SADR = 3'd3,
      SINS = 3'd4
   } stat_t;

   // True when the function code selects one of the four defined ALU operations.
   function automatic logic alu_fun_valid(input logic [3:0] fun);
      return fun <= ALUXOR;
   endfunction

endpackage

// File: rtl/y86_fetch_datapath_if.sv
// Bus bundle for the fetch/execute slice: program load port, fetch window
// outputs and the execute ALU operands/results.
interface y86_fetch_datapath_if;

   logic        load_en;
   logic [63:0] load_addr;
   logic [7:0]  load_data;
   logic [63:0] f_pc;
   logic        need_regids;
   logic [63:0] aluA;
   logic [63:0] aluB;
   logic [3:0]  alufun;

   logic [7:0]  f_ibyte;
   logic [71:0] f_ibytes;
   logic        imem_error;
   logic [3:0]  f_rA;
   logic [3:0]  f_rB;
   logic [63:0] f_valC;
   logic [63:0] e_valE;
   logic [2:0]  new_cc;

   modport master (
      output load_en, load_addr, load_data, f_pc, need_regids, aluA, aluB, alufun,
      input  f_ibyte, f_ibytes, imem_error, f_rA, f_rB, f_valC, e_valE, new_cc
   );

   modport slave (
      input  load_en, load_addr, load_data, f_pc, need_regids, aluA, aluB, alufun,
      output f_ibyte, f_ibytes, imem_error, f_rA, f_rB, f_valC, e_valE, new_cc
   );

endinterface

// File: rtl/y86_fetch_datapath_alu64.sv
// 64-bit execute ALU: add/sub/and/xor with {ZF,SF,OF} generation.
// Purely combinational; the CC register downstream decides whether to latch.
module y86_alu64
   import y86_fetch_datapath_pkg::*;
(
   input  logic [63:0] aluA,
   input  logic [63:0] aluB,
   input  logic [3:0]  alufun,
   output logic [63:0] e_valE,
   output logic [2:0]  new_cc
);

   logic of_flag;

   // Operation select; overflow is only meaningful for add/sub.
   always_comb begin
      e_valE  = 64'h0;
      of_flag = 1'b0;
      case (alufun)
         ALUADD: begin
            e_valE  = aluB + aluA;
            of_flag = (aluA[63] == aluB[63]) && (e_valE[63] != aluA[63]);
         end
         ALUSUB: begin
            e_valE  = aluB - aluA;
            of_flag = (aluA[63] != aluB[63]) && (e_valE[63] != aluB[63]);
         end
         ALUAND: e_valE = aluB & aluA;
         ALUXOR: e_valE = aluB ^ aluA;
         default: begin
            e_valE  = 64'h0;
            of_flag = 1'b0;
         end
      endcase
   end

   assign new_cc = {(e_valE == 64'h0), e_valE[63], of_flag};

endmodule

// File: rtl/y86_fetch_datapath.sv
// Y86-64 fetch/execute datapath slice: byte-wide instruction memory with a
// 10-byte combinational read window, fetch-field aligner and the execute ALU.
// Only the memory array is clocked.
module y86_fetch_datapath
   import y86_fetch_datapath_pkg::*;
#(
   parameter int MEM_BYTES = 1024
) (
   input  logic                clock,
   input  logic                resetting,
   y86_fetch_datapath_if.slave bus
);

   localparam int          AW    = $clog2(MEM_BYTES);
   localparam logic [63:0] LIMIT = 64'(MEM_BYTES);

   logic [7:0]  mem [MEM_BYTES];
   logic [7:0]  win [10];
   logic [71:0] ibytes;
   logic [63:0] alu_val;
   logic [2:0]  alu_cc;

   // Out-of-range (including wrapped) addresses read as halt bytes.
   function automatic logic [7:0] window_byte(input logic [63:0] addr);
      if (addr < LIMIT)
         return mem[addr[AW-1:0]];
      else
         return 8'h00;
   endfunction

   // Program load; reset clears the whole array to halt and blocks writes.
   always_ff @(posedge clock or negedge resetting) begin
      if (!resetting) begin
         for (int i = 0; i < MEM_BYTES; i++)
            mem[i] <= 8'h00;
      end else if (bus.load_en && (bus.load_addr < LIMIT)) begin
         mem[bus.load_addr[AW-1:0]] <= bus.load_data;
      end
   end

   // Ten-byte read window starting at f_pc, address wrap handled mod 2^64.
   always_comb begin
      for (int k = 0; k < 10; k++)
         win[k] = window_byte(bus.f_pc + 64'(k));
   end

   // Pack bytes f_pc+1..f_pc+9 little-endian into the 72-bit field.
   always_comb begin
      ibytes = 72'h0;
      for (int k = 1; k < 10; k++)
         ibytes[8*(k-1) +: 8] = win[k];
   end

   assign bus.f_ibyte    = win[0];
   assign bus.f_ibytes   = ibytes;
   assign bus.imem_error = (bus.f_pc >= LIMIT);

   // Aligner: the register byte, when present, shifts valC up by one byte.
   assign bus.f_rA   = bus.need_regids ? ibytes[7:4]  : RNONE;
   assign bus.f_rB   = bus.need_regids ? ibytes[3:0]  : RNONE;
   assign bus.f_valC = bus.need_regids ? ibytes[71:8] : ibytes[63:0];

   y86_alu64 u_alu (
      .aluA   (bus.aluA),
      .aluB   (bus.aluB),
      .alufun (bus.alufun),
      .e_valE (alu_val),
      .new_cc (alu_cc)
   );

   assign bus.e_valE = alu_val;
   assign bus.new_cc = alu_cc;

endmodule

// File: tb/tb_y86_fetch_datapath.sv
// Self-checking bench for y86_fetch_datapath: directed fetch/ALU cases plus
// randomized loads, fetches and ALU operations against a behavioural model.
module tb_y86_fetch_datapath;

   localparam int MEM_BYTES = 1024;

   logic clock = 1'b0;
   logic resetting = 1'b0;
   int   errors = 0;
   int   checks = 0;

   logic [7:0] model [MEM_BYTES];

   y86_fetch_datapath_if bus ();

   y86_fetch_datapath #(.MEM_BYTES(MEM_BYTES)) dut (
      .clock     (clock),
      .resetting (resetting),
      .bus       (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model_byte(input logic [63:0] a);
      if (a < 64'(MEM_BYTES)) return model[a[9:0]];
      return 8'h00;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < MEM_BYTES; i++) model[i] = 8'h00;
   endtask

   task automatic load_byte(input logic [63:0] addr, input logic [7:0] data);
      @(negedge clock);
      bus.load_en   = 1'b1;
      bus.load_addr = addr;
      bus.load_data = data;
      @(posedge clock);
      if (addr < 64'(MEM_BYTES)) model[addr[9:0]] = data;
      #1;
      bus.load_en = 1'b0;
   endtask

   task automatic check_fetch(input string tag, input logic [63:0] pc, input logic nr);
      logic [71:0] ib;
      logic [3:0]  ra, rb;
      logic [63:0] vc;
      @(negedge clock);
      bus.f_pc        = pc;
      bus.need_regids = nr;
      #1;
      ib = '0;
      for (int k = 1; k < 10; k++) ib[8*(k-1) +: 8] = model_byte(pc + 64'(k));
      if (nr) begin
         ra = ib[7:4]; rb = ib[3:0]; vc = ib[71:8];
      end else begin
         ra = 4'hF; rb = 4'hF; vc = ib[63:0];
      end
      chk({tag, ".ibyte"},  72'(bus.f_ibyte),    72'(model_byte(pc)));
      chk({tag, ".ibytes"}, bus.f_ibytes,        ib);
      chk({tag, ".err"},    72'(bus.imem_error), 72'(pc >= 64'(MEM_BYTES)));
      chk({tag, ".rA"},     72'(bus.f_rA),       72'(ra));
      chk({tag, ".rB"},     72'(bus.f_rB),       72'(rb));
      chk({tag, ".valC"},   72'(bus.f_valC),     72'(vc));
   endtask

   // Reference ALU using sign-extended 65-bit arithmetic for overflow.
   task automatic check_alu(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic [3:0] fn);
      logic signed [64:0] wide;
      logic [63:0] val;
      logic        of;
      @(negedge clock);
      bus.aluA = a; bus.aluB = b; bus.alufun = fn;
      #1;
      val = 64'h0; of = 1'b0;
      case (fn)
         4'd0: begin wide = $signed({b[63], b}) + $signed({a[63], a}); val = wide[63:0]; of = wide[64] ^ wide[63]; end
         4'd1: begin wide = $signed({b[63], b}) - $signed({a[63], a}); val = wide[63:0]; of = wide[64] ^ wide[63]; end
         4'd2: val = a & b;
         4'd3: val = a ^ b;
         default: val = 64'h0;
      endcase
      chk({tag, ".valE"}, 72'(bus.e_valE), 72'(val));
      chk({tag, ".cc"},   72'(bus.new_cc), 72'({val == 64'h0, val[63], of}));
   endtask

   initial begin
      logic [7:0]  prog1 [10];
      logic [7:0]  prog2 [9];
      logic [63:0] a, b, pc;

      bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
      bus.f_pc = '0; bus.need_regids = 1'b0;
      bus.aluA = '0; bus.aluB = '0; bus.alufun = '0;
      model_clear();

      repeat (3) @(negedge clock);
      resetting = 1'b1;

      // Reset state
      check_fetch("rst", 64'h0, 1'b0);
      chk("rst.ibyte_c",  72'(bus.f_ibyte), 72'h00);
      chk("rst.ibytes_c", bus.f_ibytes,     72'h0);
      chk("rst.rA_c",     72'(bus.f_rA),    72'hF);
      chk("rst.rB_c",     72'(bus.f_rB),    72'hF);

      // irmovq $8, %rdx at 0
      prog1 = '{8'h30, 8'hF2, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 10; i++) load_byte(64'(i), prog1[i]);
      check_fetch("irmov", 64'h0, 1'b1);
      chk("irmov.ibyte_c", 72'(bus.f_ibyte), 72'h30);
      chk("irmov.rA_c",    72'(bus.f_rA),    72'hF);
      chk("irmov.rB_c",    72'(bus.f_rB),    72'h2);
      chk("irmov.valC_c",  72'(bus.f_valC),  72'h8);

      // jmp 0x10 at 0x20
      prog2 = '{8'h70, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 9; i++) load_byte(64'h20 + 64'(i), prog2[i]);
      check_fetch("jmp", 64'h20, 1'b0);
      chk("jmp.rA_c",   72'(bus.f_rA),   72'hF);
      chk("jmp.rB_c",   72'(bus.f_rB),   72'hF);
      chk("jmp.valC_c", 72'(bus.f_valC), 72'h10);

      check_fetch("oob", 64'd1024, 1'b1);
      chk("oob.err_c",   72'(bus.imem_error), 72'h1);
      chk("oob.ibyte_c", 72'(bus.f_ibyte),    72'h00);
      check_fetch("last", 64'd1023, 1'b1);
      check_fetch("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);

      // Write at edge visible only after the edge
      @(negedge clock);
      bus.f_pc = 64'h0; bus.need_regids = 1'b0;
      bus.load_en = 1'b1; bus.load_addr = 64'h0; bus.load_data = 8'h55;
      #1;
      chk("nobypass.before", 72'(bus.f_ibyte), 72'h30);
      @(posedge clock);
      model[0] = 8'h55;
      #1;
      bus.load_en = 1'b0;
      chk("nobypass.after", 72'(bus.f_ibyte), 72'h55);

      // Out-of-range load dropped
      load_byte(64'd1024, 8'hEE);
      load_byte(64'hFFFF_FFFF_FFFF_FFFF, 8'hDD);
      check_fetch("droptop", 64'd1020, 1'b0);
      check_fetch("dropzero", 64'd0, 1'b1);

      // Directed ALU
      check_alu("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 4'd0);
      chk("add_ovf.valE_c", 72'(bus.e_valE), 72'h8000_0000_0000_0000);
      chk("add_ovf.cc_c",   72'(bus.new_cc), 72'b011);
      check_alu("sub_eq", 64'd5, 64'd5, 4'd1);
      chk("sub_eq.cc_c", 72'(bus.new_cc), 72'b100);
      check_alu("and_z", 64'hF0, 64'h0F, 4'd2);
      chk("and_z.cc_c", 72'(bus.new_cc), 72'b100);
      check_alu("xor_neg", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 4'd3);
      chk("xor_neg.valE_c", 72'(bus.e_valE), 72'hFFFF_FFFF_FFFF_FFFF);
      chk("xor_neg.cc_c",   72'(bus.new_cc), 72'b010);
      check_alu("inv7", 64'h1234, 64'h5678, 4'd7);
      chk("inv7.cc_c", 72'(bus.new_cc), 72'b100);
      check_alu("sub_ovf", 64'h1, 64'h8000_0000_0000_0000, 4'd1);

      // Random loads and fetches
      for (int i = 0; i < 300; i++)
         load_byte(64'($urandom_range(0, 1100)), 8'($urandom));
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0: pc = 64'($urandom_range(1010, 1030));
            1: pc = 64'hFFFF_FFFF_FFFF_FFF6 + 64'($urandom_range(0, 9));
            default: pc = 64'($urandom_range(0, 1023));
         endcase
         check_fetch("rndf", pc, 1'($urandom));
      end

      // Random ALU
      for (int i = 0; i < 200; i++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         case ($urandom_range(0, 4))
            0: b = a;
            1: begin a[62:0] = '1; b[62:0] = 63'($urandom); end
            default: ;
         endcase
         check_alu("rnda", a, b, 4'($urandom_range(0, 7)));
      end

      // Reset asserted during a load: write must not land, array cleared
      @(negedge clock);
      bus.load_en = 1'b1; bus.load_addr = 64'h50; bus.load_data = 8'hAB;
      #2;
      resetting = 1'b0;
      model_clear();
      @(posedge clock);
      #1;
      chk("rstload.during", 72'(bus.f_ibyte), 72'h00);
      @(negedge clock);
      bus.load_en = 1'b0;
      resetting = 1'b1;
      check_fetch("rstload.50", 64'h50, 1'b1);
      chk("rstload.50_c", 72'(bus.f_ibyte), 72'h00);
      check_fetch("rstload.0", 64'h0, 1'b1);
      check_fetch("rstload.20", 64'h20, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
